// File: rtl/bcd_count_ctrl_if.sv
`timescale 1ns/1ps
// bcd_count_ctrl_if: button inputs, top-digit carry and control outputs of the BCD counter controller.
// The controller sits on the slave modport; whatever drives the buttons uses master.
interface bcd_count_ctrl_if;
    logic btn_inc;
    logic btn_clr;
    logic cout_top;
    logic add1;
    logic clr;
    logic ovf;
    logic held;

    modport master (
        output btn_inc,
        output btn_clr,
        output cout_top,
        input  add1,
        input  clr,
        input  ovf,
        input  held
    );

    modport slave (
        input  btn_inc,
        input  btn_clr,
        input  cout_top,
        output add1,
        output clr,
        output ovf,
        output held
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
`timescale 1ns/1ps
// bcd_count_ctrl: debounced increment/clear pulses and sticky overflow for a cascaded BCD counter.
// Define BCD_CTRL_AUTOREPEAT_EN to compile hold-to-autorepeat on the increment button.
module bcd_count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8
) (
    input logic             ck,
    input logic             reset,
    bcd_count_ctrl_if.slave bus
);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int INC = 0;
    localparam int CLR = 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef BCD_CTRL_AUTOREPEAT_EN
    localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    logic [15:0] rc;
    logic [15:0] rc_next;
`else
    typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

    state_t state;
    state_t state_next;

    logic [1:0]    raw;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    d_lvl;
    logic [1:0]    d_next;
    logic [1:0]    accept;
    logic [DW-1:0] cnt [2];

    logic inc_rise;
    logic clr_rise;
    logic add1_q;
    logic add1_next;
    logic clr_q;
    logic ovf_q;
    logic ovf_next;

    assign raw = {bus.btn_clr, bus.btn_inc};

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // A level change is accepted on the edge that would complete the stable count,
    // so the FSM can react in that same edge rather than one cycle later.
    always_comb begin
        accept = '0;
        d_next = d_lvl;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync_b[i] != d_lvl[i]) && (cnt[i] == DB_LAST);
            if (accept[i]) begin
                d_next[i] = sync_b[i];
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            d_lvl <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            d_lvl <= d_next;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == d_lvl[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign inc_rise = accept[INC] & sync_b[INC];
    assign clr_rise = accept[CLR] & sync_b[CLR];

    always_comb begin
        state_next = state;
        add1_next  = 1'b0;
        ovf_next   = ovf_q | bus.cout_top;
`ifdef BCD_CTRL_AUTOREPEAT_EN
        rc_next    = '0;
`endif
        case (state)
            IDLE: begin
                if (inc_rise) begin
                    add1_next  = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!d_lvl[INC]) begin
                    state_next = IDLE;
`ifdef BCD_CTRL_AUTOREPEAT_EN
                end else if (rc == DELAY_LAST) begin
                    add1_next  = 1'b1;
                    state_next = REPEAT;
                end else begin
                    rc_next = rc + 16'd1;
`endif
                end
            end
`ifdef BCD_CTRL_AUTOREPEAT_EN
            REPEAT: begin
                if (!d_lvl[INC]) begin
                    state_next = IDLE;
                end else if (rc == PERIOD_LAST) begin
                    add1_next = 1'b1;
                end else begin
                    rc_next = rc + 16'd1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Clear overrides everything: no increment, overflow dropped, and a press
        // that is still down parks in HELD so it only repeats after the full delay.
        if (clr_rise) begin
            add1_next  = 1'b0;
            ovf_next   = 1'b0;
            state_next = d_next[INC] ? HELD : IDLE;
`ifdef BCD_CTRL_AUTOREPEAT_EN
            rc_next    = '0;
`endif
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            add1_q <= 1'b0;
            clr_q  <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef BCD_CTRL_AUTOREPEAT_EN
            rc     <= '0;
`endif
        end else begin
            state  <= state_next;
            add1_q <= add1_next;
            clr_q  <= clr_rise;
            ovf_q  <= ovf_next;
`ifdef BCD_CTRL_AUTOREPEAT_EN
            rc     <= rc_next;
`endif
        end
    end

    assign bus.add1 = add1_q;
    assign bus.clr  = clr_q;
    assign bus.ovf  = ovf_q;
    assign bus.held = d_lvl[INC];

endmodule

// File: tb/tb_bcd_count_ctrl.sv
`timescale 1ns/1ps
// tb_bcd_count_ctrl: directed-vector bench for bcd_count_ctrl with defaults 4/20/8 and a 10 ns clock.
// Expected pulse edges are hand-computed from the press/release latency and repeat spacing.
module tb_bcd_count_ctrl;
    localparam int LOGN = 1024;

    logic ck;
    logic reset;
    logic manualCout;
    logic useChain;
    logic loadReq;
    logic chainCout;
    logic [3:0] units;
    logic [3:0] tens;

    int cyc;
    int errCount;
    int checkCount;
    int dblAdd1;
    int dblClr;
    logic prevAdd1;
    logic prevClr;
    logic add1Log [LOGN];
    logic clrLog  [LOGN];
    logic ovfLog  [LOGN];
    logic heldLog [LOGN];

    bcd_count_ctrl_if bus();

    bcd_count_ctrl dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Two-digit BCD chain (units into tens) so the top carry comes from real counting.
    assign chainCout = bus.add1 && (units == 4'd9) && (tens == 4'd9);
    assign bus.cout_top = useChain ? chainCout : manualCout;

    always @(posedge ck) begin
        if (loadReq) begin
            units <= 4'd7;
            tens  <= 4'd9;
        end else if (bus.clr) begin
            units <= 4'd0;
            tens  <= 4'd0;
        end else if (bus.add1) begin
            if (units == 4'd9) begin
                units <= 4'd0;
                tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drives the buttons, then advances n clocks, logging outputs #1 after each edge.
    task automatic applyStimulus(input logic inc, input logic clrBtn, input int n);
        bus.btn_inc = inc;
        bus.btn_clr = clrBtn;
        for (int k = 0; k < n; k++) begin
            @(posedge ck);
            #1;
            cyc++;
            if (cyc < LOGN) begin
                add1Log[cyc] = bus.add1;
                clrLog[cyc]  = bus.clr;
                ovfLog[cyc]  = bus.ovf;
                heldLog[cyc] = bus.held;
            end
            if (bus.add1 && prevAdd1) dblAdd1++;
            if (bus.clr && prevClr) dblClr++;
            prevAdd1 = bus.add1;
            prevClr  = bus.clr;
        end
    endtask

    function automatic int countAdd1(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi && k < LOGN; k++) begin
            if (add1Log[k]) n++;
        end
        return n;
    endfunction

    function automatic int countClr(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi && k < LOGN; k++) begin
            if (clrLog[k]) n++;
        end
        return n;
    endfunction

    // Offset from lo of the nth (0-based) add1 pulse in [lo,hi], or -1 if absent.
    function automatic int nthAdd1(input int lo, input int hi, input int nth);
        int n = 0;
        for (int k = lo; k <= hi && k < LOGN; k++) begin
            if (add1Log[k]) begin
                if (n == nth) return k - lo;
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int a;
        cyc = 0;
        errCount = 0;
        checkCount = 0;
        dblAdd1 = 0;
        dblClr = 0;
        prevAdd1 = 1'b0;
        prevClr = 1'b0;
        reset = 1'b0;
        manualCout = 1'b0;
        useChain = 1'b0;
        loadReq = 1'b0;
        bus.btn_inc = 1'b0;
        bus.btn_clr = 1'b0;

        #3;
        checkOutput("rstAdd1", int'(bus.add1), 0);
        checkOutput("rstClr",  int'(bus.clr),  0);
        checkOutput("rstOvf",  int'(bus.ovf),  0);
        checkOutput("rstHeld", int'(bus.held), 0);
        applyStimulus(1'b0, 1'b0, 3);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 5);

        $display("[TB] clean press");
        e0 = cyc + 1;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("cleanCount", countAdd1(e0, cyc), 1);
        checkOutput("cleanEdge", nthAdd1(e0, cyc, 0), 5);
        checkOutput("heldBefore", int'(heldLog[e0 + 4]), 0);
        checkOutput("heldRise", int'(heldLog[e0 + 5]), 1);
        checkOutput("heldLast", int'(heldLog[e0 + 14]), 1);
        checkOutput("heldFall", int'(heldLog[e0 + 15]), 0);

        $display("[TB] bounce");
        e0 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(((i / 2) % 2) == 0, 1'b0, 1);
        end
        applyStimulus(1'b1, 1'b0, 15);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("bounceCount", countAdd1(e0, cyc), 1);
        checkOutput("bounceEdge", nthAdd1(e0, cyc, 0), 17);

        $display("[TB] hold");
        e0 = cyc + 1;
        applyStimulus(1'b1, 1'b0, 50);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("holdFirst", nthAdd1(e0, cyc, 0), 5);
`ifdef BCD_CTRL_AUTOREPEAT_EN
        checkOutput("holdCount", countAdd1(e0, cyc), 5);
        checkOutput("holdRpt1", nthAdd1(e0, cyc, 1), 25);
        checkOutput("holdRpt2", nthAdd1(e0, cyc, 2), 33);
        checkOutput("holdRpt4", nthAdd1(e0, cyc, 4), 49);
`else
        checkOutput("holdCount", countAdd1(e0, cyc), 1);
`endif

        $display("[TB] clear priority");
        manualCout = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        manualCout = 1'b0;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("ovfSet", int'(bus.ovf), 1);
        e0 = cyc + 1;
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b1, 1'b0, 22);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("clrEdge", int'(clrLog[e0 + 5]), 1);
        checkOutput("clrCount", countClr(e0, cyc), 1);
        checkOutput("prioNoAdd1", countAdd1(e0, e0 + 24), 0);
        checkOutput("prioOvfBefore", int'(ovfLog[e0 + 4]), 1);
        checkOutput("prioOvfAfter", int'(ovfLog[e0 + 5]), 0);
        checkOutput("prioHeld", int'(heldLog[e0 + 5]), 1);
`ifdef BCD_CTRL_AUTOREPEAT_EN
        checkOutput("prioRptEdge", nthAdd1(e0, cyc, 0), 25);
`else
        checkOutput("prioAdd1Total", countAdd1(e0, cyc), 0);
`endif

        $display("[TB] overflow");
        useChain = 1'b1;
        loadReq = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        loadReq = 1'b0;
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("chainAt99", int'(tens) * 10 + int'(units), 99);
        checkOutput("ovfBeforeWrap", int'(bus.ovf), 0);
        e0 = cyc + 1;
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 8);
        a = e0 + nthAdd1(e0, cyc, 0);
        checkOutput("wrapAdd1Seen", nthAdd1(e0, cyc, 0), 5);
        checkOutput("ovfAtAdd1", int'(ovfLog[a]), 0);
        checkOutput("ovfNextEdge", int'(ovfLog[a + 1]), 1);
        checkOutput("chainWrapped", int'(tens) * 10 + int'(units), 0);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("ovfSticky", int'(bus.ovf), 1);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("ovfCleared", int'(bus.ovf), 0);
        useChain = 1'b0;

        $display("[TB] reset mid-hold");
        manualCout = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        manualCout = 1'b0;
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("preRstHeld", int'(bus.held), 1);
        reset = 1'b0;
        #1;
        checkOutput("midRstAdd1", int'(bus.add1), 0);
        checkOutput("midRstClr",  int'(bus.clr),  0);
        checkOutput("midRstOvf",  int'(bus.ovf),  0);
        checkOutput("midRstHeld", int'(bus.held), 0);
        applyStimulus(1'b1, 1'b0, 3);
        reset = 1'b1;
        e0 = cyc + 1;
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("rstPressEdge", nthAdd1(e0, cyc, 0), 5);
        checkOutput("rstPressCount", countAdd1(e0, cyc), 1);
        applyStimulus(1'b0, 1'b0, 10);

        checkOutput("add1Width", dblAdd1, 0);
        checkOutput("clrWidth", dblClr, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Input controller for the cascaded BCD counter chain in the button counter design. It debounces a raw increment button and a raw clear button. It issues single-cycle `add1` and `clr` pulses to the least-significant BCD digit, with optional hold-to-autorepeat. It also keeps a sticky overflow flag from the top digit's carry out.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change (≥1).
- `REPEAT_DELAY`, 20: cycles from the initial `add1` to the first repeat `add1` while held (≥2).
- `REPEAT_PERIOD`, 8: cycles between subsequent repeat `add1` pulses (≥2).
- `ck` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_inc` in 1: raw, asynchronous increment button, active-high.
- `btn_clr` in 1: raw, asynchronous clear button, active-high.
- `cout_top` in 1: carry out of the most-significant BCD digit.
- `add1` out 1: one-cycle increment pulse to the least-significant digit.
- `clr` out 1: one-cycle synchronous clear pulse to all digits.
- `ovf` out 1: sticky overflow flag.
- `held` out 1: debounced increment level.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, giving `s_inc` and `s_clr`.
- **Debouncer:**
  - One debouncer per button, each with a debounced level `d` and a counter `cnt`.
  - If `s == d`: `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`. When `cnt+1 == DEBOUNCE_CYCLES`, `d <= s` and `cnt <= 0`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Clear:**
  - A rising edge of `d_clr` registers `clr=1` for one cycle.
  - In the same edge: `ovf <= 0`, the increment FSM goes to IDLE (or HELD if `d_inc` stays high) and the repeat counter is zeroed.
- **Increment FSM:** states IDLE, HELD, REPEAT; 16-bit repeat counter `rc`.
  - IDLE: on `d_inc` rising, `add1=1`, `rc <= 0`, go to HELD.
  - HELD: `rc` increments each cycle. When `rc+1 == REPEAT_DELAY`, `add1=1`, `rc <= 0`, go to REPEAT. Going to REPEAT requires the macro (see Configuration).
  - REPEAT: `rc` increments each cycle. When `rc+1 == REPEAT_PERIOD`, `add1=1`, `rc <= 0`.
  - HELD or REPEAT with `d_inc==0`: go to IDLE, no pulse.
- **Priority:**
  - A cycle that would assert both `clr` and `add1` asserts `clr` only; `add1` is suppressed.
  - A suppressed initial press still enters HELD.
- **Overflow:**
  - `ovf <= 1` at any edge where `cout_top==1`.
  - Cleared only by `clr` or reset; `clr` wins if both occur in the same cycle.
- **Outputs:** `add1`, `clr` and `ovf` are registered outputs. `held = d_inc`.

## Timing
- **Reset:** asynchronous, active-low. While `reset==0`:
  - `add1=0`, `clr=0`, `ovf=0`, `held=0`.
  - Synchronizers 0, debounce levels and counters 0.
  - FSM in IDLE, `rc=0`.
- **Release:** first active edge is the first rising `ck` with `reset==1`.
- **Press latency:** a clean input first sampled high at edge 0 gives `add1` high from edge `DEBOUNCE_CYCLES+1` to edge `DEBOUNCE_CYCLES+2`. With defaults, `add1` rises at edge 5. Same latency for `clr`.
- **Release latency:** `d` falls `DEBOUNCE_CYCLES+1` edges after the input is first sampled low.
- **Bounce:** any synchronized sample equal to `d` restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- **Repeat spacing:** the initial `add1` is at edge t0; repeats follow at t0+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles.
- **Pulse width:** `add1` and `clr` are never high for two consecutive cycles.
- **Reset mid-hold:** all state is cleared. After release, a button still held produces a fresh press after full debounce latency.

## Configuration
- `BCD_CTRL_AUTOREPEAT_EN` defined:
  - HELD → REPEAT enabled as described.
- Undefined:
  - REPEAT state and the HELD timeout are not compiled.
  - HELD waits only for `d_inc` low.
  - Exactly one `add1` per debounced press.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
All scenarios use defaults (4/20/8) and a 10 ns `ck`.
- **Reset:** assert `reset=0` mid-hold for 3 cycles, with `cout_top=1` at least one cycle beforehand → immediately `add1=0`, `clr=0`, `ovf=0`, `held=0`. After release with the button still high, the first `add1` arrives 5 edges later.
- **Clean press:** `btn_inc` high for 10 cycles then low → exactly one `add1`, at edge 5; `held` high edges 5–15. With the macro defined, no repeat occurs (10 < 20).
- **Bounce:** `btn_inc` toggles every 2 cycles for 12 cycles, then stays high 15 cycles → exactly one `add1`, 5 edges after the final rise.
- **Autorepeat (macro defined):** hold so that `d_inc` stays high 50 cycles after t0 → `add1` at t0, t0+20, t0+28, t0+36, t0+44, i.e. 5 pulses. Macro undefined → 1 pulse.
- **Clear priority:** `btn_inc` and `btn_clr` rise on the same cycle with `ovf=1` → `clr` pulses at edge 5, `add1` stays 0 throughout, `ovf` goes 0. The held button produces repeats only after `REPEAT_DELAY`.
- **Overflow:** drive the two-digit chain (units into tens) from `add1` until the tens `cout` fires at count 99→00 → `ovf=1` the next edge and stays 1 until a `clr` pulse.
